// File: rtl/arb_rr_pktlock.sv
// arb_rr_pktlock: N-port round-robin output-port allocator with packet lock.
// Multicast class priority, contention masking and a starvation override.
module arb_rr_pktlock #(
    parameter int N          = 5,
    parameter int IDW        = $clog2(N),
    parameter int STARVE_MAX = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   u_req,
    input  logic [N-1:0]   m_req,
    input  logic [N-1:0]   multab_ct,
    input  logic           tail_done,
    output logic [N-1:0]   grt,
    output logic [IDW-1:0] grt_id,
    output logic           grt_mc,
    output logic           busy
);

    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [SW-1:0]  scnt;

    logic           starve;
    logic           cls_mc;
    logic [N-1:0]   elig;
    logic           found;
    logic [IDW-1:0] win;
    logic [N-1:0]   win_oh;
    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] ptr_nxt;
    logic [SW-1:0]  scnt_nxt;
    logic           rel;

    // Class selection: starvation override, else multicast, else unicast.
    // A pending multicast blocks unicast even when every m_req is masked.
    always_comb begin
        starve = (STARVE_MAX != 0) && (int'(scnt) == STARVE_MAX) && (|u_req);
        cls_mc = 1'b0;
        elig   = u_req;
        priority case (1'b1)
            starve: begin
                cls_mc = 1'b0;
                elig   = u_req;
            end
            (|m_req): begin
                cls_mc = 1'b1;
                elig   = m_req & ~multab_ct;
            end
            default: begin
                cls_mc = 1'b0;
                elig   = u_req;
            end
        endcase
    end

    // Rotating first-set search starting at ptr, wrapping at N.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N))
                sum = sum - (IDW+1)'(N);
            idx = sum[IDW-1:0];
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        win_oh      = '0;
        win_oh[win] = 1'b1;
    end

    // Next pointer, starvation count and release condition.
    always_comb begin
        ptr_nxt = (int'(win) == N - 1) ? '0 : win + 1'b1;
        if (cls_mc && (|u_req)) begin
            if (int'(scnt) >= STARVE_MAX)
                scnt_nxt = scnt;
            else
                scnt_nxt = scnt + SW'(1);
        end else begin
            scnt_nxt = '0;
        end
        rel = tail_done || !(u_req[grt_id] || m_req[grt_id]);
    end

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            scnt   <= '0;
            grt    <= '0;
            grt_id <= '0;
            grt_mc <= 1'b0;
            busy   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state  <= LOCKED;
                        grt    <= win_oh;
                        grt_id <= win;
                        grt_mc <= cls_mc;
                        busy   <= 1'b1;
                        ptr    <= ptr_nxt;
                        scnt   <= scnt_nxt;
                    end
                end
                LOCKED: begin
                    if (rel) begin
                        state  <= IDLE;
                        grt    <= '0;
                        grt_mc <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arb_rr_pktlock.sv
// tb_arb_rr_pktlock: directed scoreboard bench for arb_rr_pktlock.
// Expected grants are queued by the stimulus and popped by a monitor.
module tb_arb_rr_pktlock;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] u_req;
    logic [4:0] m_req;
    logic [4:0] multab_ct;
    logic       tail_done;
    logic [4:0] grt;
    logic [2:0] grt_id;
    logic       grt_mc;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0] g;
        logic [2:0] id;
        logic       mc;
    } exp_t;

    exp_t q[$];
    logic busy_q = 1'b0;

    arb_rr_pktlock #(.N(5), .IDW(3), .STARVE_MAX(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .u_req     (u_req),
        .m_req     (m_req),
        .multab_ct (multab_ct),
        .tail_done (tail_done),
        .grt       (grt),
        .grt_id    (grt_id),
        .grt_mc    (grt_mc),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] g, input logic [2:0] id,
                        input logic mc);
        exp_t e;
        e.g  = g;
        e.id = id;
        e.mc = mc;
        q.push_back(e);
    endtask

    task automatic wait_busy();
        int t;
        t = 0;
        while (!busy && t < 20) begin
            tick();
            t++;
        end
        if (!busy) begin
            checks++;
            failures++;
            $display("FAIL wait_busy actual=0 required=1");
        end
    endtask

    // Serve n packets: wait for a grant, pulse tail_done for one cycle.
    // Requests are dropped together with the last tail.
    task automatic serve(input int n);
        for (int i = 0; i < n; i++) begin
            wait_busy();
            tail_done = 1'b1;
            if (i == n - 1) begin
                u_req = '0;
                m_req = '0;
            end
            tick();
            tail_done = 1'b0;
        end
    endtask

    // Monitor: every new grant must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (busy && !busy_q) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_grant actual=%0h required=none",
                         {grt, grt_id, grt_mc});
            end else begin
                e = q.pop_front();
                chk("grant", {23'd0, grt, grt_id, grt_mc}, {23'd0, e});
            end
        end
        busy_q = busy;
    end

    initial begin
        rst       = 1'b1;
        u_req     = 5'b11111;
        m_req     = 5'b11111;
        multab_ct = '0;
        tail_done = 1'b0;
        tick();
        tick();
        chk("rst_grt", {27'd0, grt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_id", {29'd0, grt_id}, 32'd0);

        // Reset release: port 2 first, then port 4 proves ptr=3.
        push(5'b00100, 3'd2, 1'b0);
        push(5'b10000, 3'd4, 1'b0);
        rst   = 1'b0;
        u_req = 5'b10100;
        m_req = '0;
        serve(2);

        // Rotation with wrap from ptr=0.
        push(5'b00001, 3'd0, 1'b0);
        push(5'b00010, 3'd1, 1'b0);
        push(5'b00100, 3'd2, 1'b0);
        push(5'b01000, 3'd3, 1'b0);
        push(5'b10000, 3'd4, 1'b0);
        push(5'b00001, 3'd0, 1'b0);
        u_req = 5'b11111;
        serve(6);

        // Multicast priority with contention mask, ptr=1.
        push(5'b01000, 3'd3, 1'b1);
        u_req     = 5'b00001;
        m_req     = 5'b01010;
        multab_ct = 5'b00010;
        serve(1);
        u_req     = 5'b00001;
        m_req     = 5'b00010;
        multab_ct = 5'b00010;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("masked_busy", {31'd0, busy}, 32'd0);
        end
        chk("masked_grt", {27'd0, grt}, 32'd0);
        u_req     = '0;
        m_req     = '0;
        multab_ct = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Starvation override from scnt=0.
        push(5'b10000, 3'd4, 1'b1);
        push(5'b10000, 3'd4, 1'b1);
        push(5'b00001, 3'd0, 1'b0);
        push(5'b10000, 3'd4, 1'b1);
        u_req = 5'b00001;
        m_req = 5'b10000;
        serve(4);

        // Lock holds through input changes, then requester abort.
        push(5'b00100, 3'd2, 1'b0);
        u_req = 5'b00100;
        wait_busy();
        multab_ct = 5'b11111;
        u_req     = 5'b11111;
        m_req     = 5'b11011;
        tick();
        chk("lock_grt0", {27'd0, grt}, 32'h04);
        multab_ct = 5'b00000;
        tick();
        chk("lock_grt1", {27'd0, grt}, 32'h04);
        chk("lock_mc", {31'd0, grt_mc}, 32'd0);
        u_req     = '0;
        m_req     = '0;
        tick();
        chk("abort_grt", {27'd0, grt}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_id", {29'd0, grt_id}, 32'd2);

        // Reset mid-packet on port 3 (ptr=3 now).
        push(5'b01000, 3'd3, 1'b0);
        u_req = 5'b01000;
        wait_busy();
        rst = 1'b1;
        tick();
        chk("mid_rst_grt", {27'd0, grt}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_id", {29'd0, grt_id}, 32'd0);
        push(5'b00001, 3'd0, 1'b0);
        rst   = 1'b0;
        u_req = 5'b11111;
        serve(1);

        tick();
        tick();
        chk("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
